// File: rtl/mhd_pkg.sv
// Shared types and helpers for the Hamming-distance monitor family.
// Holds the capture state encoding and the distance-width function.
package mhd_pkg;

  typedef logic [0:0] cap_state_t;

  localparam cap_state_t ARMED    = 1'b0;
  localparam cap_state_t CAPTURED = 1'b1;

  function automatic int hd_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mhd_popcount.sv
// Combinational population count of a WIDTH-bit vector.
// Ports: v (input vector), cnt (number of set bits, HD_W wide).
module mhd_popcount
  import mhd_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int HD_W  = hd_width(WIDTH)
) (
  input  logic [WIDTH-1:0] v,
  output logic [HD_W-1:0]  cnt
);

  // Written as a reduction loop; synthesis balances it into a tree.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + HD_W'(v[i]);
    end
  end

endmodule

// File: rtl/mhd_stream_monitor.sv
// Two-stage streaming Hamming-distance monitor with threshold check,
// saturating statistics and first-violation capture.
// Ports: clk, rst (async high), clear (sync), in_valid/a/b/thresh in;
//   out_valid/hd/viol per sample; sample_cnt/viol_cnt/max_hd stats;
//   captured/cap_index/cap_diff describe the first violation.
module mhd_stream_monitor
  import mhd_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int CNT_W = 32,
  parameter int HD_W  = hd_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [HD_W-1:0]  thresh,
  output logic             out_valid,
  output logic [HD_W-1:0]  hd,
  output logic             viol,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] viol_cnt,
  output logic [HD_W-1:0]  max_hd,
  output logic             captured,
  output logic [CNT_W-1:0] cap_index,
  output logic [WIDTH-1:0] cap_diff
);

  logic             v1;
  logic [WIDTH-1:0] d1;
  logic [HD_W-1:0]  t1;
  logic [HD_W-1:0]  hd_c;
  logic             viol_c;
  cap_state_t       state;

  // Stage 1: register the difference vector and threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      d1 <= '0;
      t1 <= '0;
    end else if (clear) begin
      v1 <= 1'b0;
      d1 <= '0;
      t1 <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        d1 <= a ^ b;
        t1 <= thresh;
      end
    end
  end

  mhd_popcount #(
    .WIDTH (WIDTH),
    .HD_W  (HD_W)
  ) u_pop (
    .v   (d1),
    .cnt (hd_c)
  );

  // Strict compare: a distance equal to the threshold is allowed.
  assign viol_c = hd_c > t1;

  // Stage 2: per-sample result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      hd        <= '0;
      viol      <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      hd        <= '0;
      viol      <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        hd   <= hd_c;
        viol <= viol_c;
      end
    end
  end

  // Statistics, updated alongside the stage-2 result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      viol_cnt   <= '0;
      max_hd     <= '0;
    end else if (clear) begin
      sample_cnt <= '0;
      viol_cnt   <= '0;
      max_hd     <= '0;
    end else if (v1) begin
      if (sample_cnt != '1) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
      end
      if (viol_c && viol_cnt != '1) begin
        viol_cnt <= viol_cnt + CNT_W'(1);
      end
      if (hd_c > max_hd) begin
        max_hd <= hd_c;
      end
    end
  end

  // First-violation capture. The index is the pre-increment count,
  // which already reads all-ones once the counter has saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARMED;
      cap_index <= '0;
      cap_diff  <= '0;
    end else if (clear) begin
      state     <= ARMED;
      cap_index <= '0;
      cap_diff  <= '0;
    end else begin
      unique case (1'b1)
        (state == ARMED): begin
          if (v1 && viol_c) begin
            cap_index <= sample_cnt;
            cap_diff  <= d1;
            state     <= CAPTURED;
          end
        end
        default: begin
          state <= CAPTURED;
        end
      endcase
    end
  end

  assign captured = (state == CAPTURED);

endmodule

// File: tb/tb_mhd_stream_monitor.sv
// Directed bench for mhd_stream_monitor: a WIDTH=9 instance and a
// WIDTH=1/CNT_W=4 instance sharing one clock and reset.
module tb_mhd_stream_monitor;

  logic       clk = 1'b0;
  logic       rst;

  logic       clr;
  logic       iv;
  logic [8:0] a;
  logic [8:0] b;
  logic [3:0] th;
  logic       ov;
  logic [3:0] hd;
  logic       vi;
  logic [31:0] sc;
  logic [31:0] vc;
  logic [3:0] mx;
  logic       cp;
  logic [31:0] ci;
  logic [8:0] cd;

  logic       q_clr;
  logic       q_iv;
  logic [0:0] q_a;
  logic [0:0] q_b;
  logic [0:0] q_th;
  logic       q_ov;
  logic [0:0] q_hd;
  logic       q_vi;
  logic [3:0] q_sc;
  logic [3:0] q_vc;
  logic [0:0] q_mx;
  logic       q_cp;
  logic [3:0] q_ci;
  logic [0:0] q_cd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mhd_stream_monitor #(
    .WIDTH (9),
    .CNT_W (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clr),
    .in_valid   (iv),
    .a          (a),
    .b          (b),
    .thresh     (th),
    .out_valid  (ov),
    .hd         (hd),
    .viol       (vi),
    .sample_cnt (sc),
    .viol_cnt   (vc),
    .max_hd     (mx),
    .captured   (cp),
    .cap_index  (ci),
    .cap_diff   (cd)
  );

  mhd_stream_monitor #(
    .WIDTH (1),
    .CNT_W (4)
  ) dut1 (
    .clk        (clk),
    .rst        (rst),
    .clear      (q_clr),
    .in_valid   (q_iv),
    .a          (q_a),
    .b          (q_b),
    .thresh     (q_th),
    .out_valid  (q_ov),
    .hd         (q_hd),
    .viol       (q_vi),
    .sample_cnt (q_sc),
    .viol_cnt   (q_vc),
    .max_hd     (q_mx),
    .captured   (q_cp),
    .cap_index  (q_ci),
    .cap_diff   (q_cd)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int         sent;
  logic       lv;
  logic [3:0] lhd;
  logic       lvi;
  logic       cv;
  logic [3:0] chd;
  logic       cvi;

  initial begin
    rst = 1'b1;
    clr = 1'b0; iv = 1'b0; a = '0; b = '0; th = '0;
    q_clr = 1'b0; q_iv = 1'b0; q_a = '0; q_b = '0; q_th = '0;
    tick();
    tick();
    chk("rst_ov", ov, 0);
    chk("rst_hd", hd, 0);
    chk("rst_sc", sc, 0);
    chk("rst_cp", cp, 0);
    chk("rst_ci", ci, 0);
    chk("rst_cd", cd, 0);
    rst = 1'b0;
    tick();

    // Directed: thresh 4, distances 4, 5, 9.
    th = 4'd4; a = 9'h000;
    iv = 1'b1; b = 9'h00F; tick();
    b = 9'h01F; tick();
    chk("d0_ov", ov, 1);
    chk("d0_hd", hd, 4);
    chk("d0_vi", vi, 0);
    b = 9'h1FF; tick();
    chk("d1_hd", hd, 5);
    chk("d1_vi", vi, 1);
    iv = 1'b0; tick();
    chk("d2_hd", hd, 9);
    chk("d2_vi", vi, 1);
    tick();
    chk("d_ov0", ov, 0);
    chk("d_sc", sc, 3);
    chk("d_vc", vc, 2);
    chk("d_mx", mx, 9);
    chk("d_cp", cp, 1);
    chk("d_ci", ci, 1);
    chk("d_cd", cd, 9'h01F);

    // Clear with in_valid while two samples are in flight.
    iv = 1'b1; b = 9'h0FF; tick();
    tick();
    clr = 1'b1; tick();
    chk("c_ov", ov, 0);
    chk("c_sc", sc, 0);
    chk("c_vc", vc, 0);
    chk("c_mx", mx, 0);
    chk("c_cp", cp, 0);
    chk("c_ci", ci, 0);
    chk("c_cd", cd, 0);
    clr = 1'b0; iv = 1'b0; tick();
    chk("c_flush1", ov, 0);
    tick();
    chk("c_flush2", ov, 0);
    chk("c_sc2", sc, 0);
    iv = 1'b1; b = 9'h1F0; tick();
    iv = 1'b0; tick();
    chk("c_re_ov", ov, 1);
    chk("c_re_hd", hd, 5);
    chk("c_re_cp", cp, 1);
    chk("c_re_ci", ci, 0);
    chk("c_re_cd", cd, 9'h1F0);
    chk("c_re_sc", sc, 1);

    // Random gaps: 100 samples against a one-deep delay model.
    clr = 1'b1; tick();
    clr = 1'b0;
    sent = 0;
    lv = 1'b0; lhd = '0; lvi = 1'b0;
    while (sent < 100) begin
      cv = ($urandom_range(0, 2) != 0);
      iv = cv;
      a = 9'($urandom);
      b = 9'($urandom);
      th = 4'($urandom_range(0, 10));
      chd = 4'($countones(a ^ b));
      cvi = chd > th;
      if (cv) sent++;
      tick();
      chk("r_ov", ov, lv);
      if (lv) begin
        chk("r_hd", hd, lhd);
        chk("r_vi", vi, lvi);
      end
      lv = cv; lhd = chd; lvi = cvi;
    end
    iv = 1'b0; tick();
    chk("r_ov_last", ov, lv);
    if (lv) chk("r_hd_last", hd, lhd);
    tick();
    chk("r_sc", sc, 100);

    // Async reset between clock edges.
    th = 4'd4; a = 9'h000; b = 9'h0FF; iv = 1'b1;
    tick(); tick(); tick();
    chk("a_pre_cp", cp, 1);
    #3 rst = 1'b1;
    #1;
    chk("a_ov", ov, 0);
    chk("a_sc", sc, 0);
    chk("a_mx", mx, 0);
    chk("a_cp", cp, 0);
    #1 rst = 1'b0;
    tick();
    chk("a_lat1", ov, 0);
    tick();
    chk("a_lat2", ov, 1);
    chk("a_hd", hd, 8);
    iv = 1'b0;

    // WIDTH=1, CNT_W=4: saturation and threshold edges.
    q_a = 1'b1; q_b = 1'b0; q_th = 1'b0; q_iv = 1'b1;
    tick(); tick();
    chk("w1_vi", q_vi, 1);
    chk("w1_hd", q_hd, 1);
    repeat (18) tick();
    q_iv = 1'b0; tick(); tick();
    chk("s_sc", q_sc, 15);
    chk("s_vc", q_vc, 15);
    chk("s_mx", q_mx, 1);
    chk("s_cp", q_cp, 1);
    chk("s_ci", q_ci, 0);
    q_th = 1'b1; q_iv = 1'b1; tick();
    q_iv = 1'b0; tick();
    chk("w1t1_ov", q_ov, 1);
    chk("w1t1_vi", q_vi, 0);
    chk("w1t1_hd", q_hd, 1);
    q_clr = 1'b1; tick();
    q_clr = 1'b0; q_iv = 1'b1; q_th = 1'b1;
    repeat (15) tick();
    q_th = 1'b0; tick();
    q_iv = 1'b0; tick(); tick();
    chk("sc_sc", q_sc, 15);
    chk("sc_vc", q_vc, 1);
    chk("sc_cp", q_cp, 1);
    chk("sc_ci", q_ci, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mhd_stream_monitor.md
# mhd_stream_monitor

Streaming Hamming-distance monitor for approximate-circuit evaluation. It accepts one pair of exact and approximate output vectors per cycle and computes their Hamming distance in a 2-stage pipeline. Each sample is flagged when the distance exceeds a runtime threshold, and running statistics are kept: sample count, violation count, maximum distance, and a first-violation capture. It sits between the exact/approximate simulation harness and the error-report logic, replacing the fixed-width, fixed-threshold combinational miter with a parametrised, observable block.

## Interface
- WIDTH, 9, bit width of compared vectors (≥1)
- CNT_W, 32, width of sample/violation counters and capture index
- HD_W, $clog2(WIDTH+1), distance width (derived, not overridden)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous clear of statistics, capture, pipeline
- in_valid  in  1  sample present on a/b this cycle
- a  in  WIDTH  exact output vector
- b  in  WIDTH  approximate output vector
- thresh  in  HD_W  max allowed distance, sampled with the data
- out_valid  out  1  per-sample result valid
- hd  out  HD_W  Hamming distance of the result sample
- viol  out  1  hd > thresh for the result sample
- sample_cnt  out  CNT_W  accepted samples, saturating
- viol_cnt  out  CNT_W  violating samples, saturating
- max_hd  out  HD_W  largest hd seen since reset/clear
- captured  out  1  a first violation has been captured
- cap_index  out  CNT_W  sample_cnt value of the first violating sample (0-based)
- cap_diff  out  WIDTH  a^b of the first violating sample

## Operation
- Stage 1 (on in_valid): register d1 = a^b, t1 = thresh, v1 = 1; otherwise v1 = 0.
- Stage 2: hd = popcount(d1) (zero-extended to HD_W), viol = (hd > t1), out_valid = v1.
- Statistics update on the cycle stage-2 data is registered (uses stage-2 inputs, i.e. v1).
- Counters increment by 1 per valid result and saturate at 2^CNT_W-1. No wrap.
- max_hd updates when hd > max_hd.
- Capture FSM (states in package):
  - ARMED: on valid and viol, latch cap_index = current sample_cnt (pre-increment) and cap_diff = d1, then go to CAPTURED.
  - CAPTURED: holds; ignores further violations. Exits only on clear or rst.
  - captured = (state == CAPTURED).
- If sample_cnt is saturated at capture, cap_index = 2^CNT_W-1.
- Comparison is strict: hd == thresh is not a violation (matches existing miter semantics). thresh ≥ WIDTH never violates.

## Timing
- Reset values: out_valid 0, hd 0, viol 0, sample_cnt 0, viol_cnt 0, max_hd 0, captured 0, cap_index 0, cap_diff 0, FSM ARMED, v1 0.
- Latency: sample on cycle N appears on out_valid/hd/viol at cycle N+2. Statistics reflect it from N+2.
- Full throughput: one sample per cycle, no backpressure. in_valid gaps produce out_valid gaps.
- clear (synchronous) flushes v1 and out_valid to 0 and zeroes all statistics and capture in one cycle. The FSM returns to ARMED.
- clear and in_valid in the same cycle: clear wins and the sample is dropped. Samples in flight at clear are discarded.
- rst asserted mid-stream: all state goes to reset values immediately. The first valid result is 2 cycles after the first post-reset in_valid.
- A violation on the same cycle the counter saturates is captured normally.

## Structure
- Package mhd_pkg holds:
  - the capture state typedef (ARMED, CAPTURED);
  - the hd_width(WIDTH) function returning $clog2(WIDTH+1).
- Sub-module mhd_popcount: purely combinational adder tree, parameter WIDTH, input vector, output HD_W count. It is reused by later miter variants.
- Top module: pipeline registers, comparator, counters, FSM.

## Test plan
- WIDTH=9, thresh=4: a=0x000 with b=0x00F, 0x01F, 0x1FF on consecutive cycles -> hd 4, 5, 9; viol 0, 1, 1; viol_cnt 2; max_hd 9; cap_index 1; cap_diff 0x01F.
- Back-to-back 100 samples with random gaps -> out_valid is exactly in_valid delayed 2 cycles; sample_cnt equals the number of valid samples; hd matches a software popcount.
- CNT_W=4: feed 20 violating samples -> sample_cnt and viol_cnt stick at 15, with no wrap.
- clear asserted together with in_valid while 2 samples are in flight -> next cycle out_valid 0, all statistics 0, captured 0; the next violation is recaptured with cap_index 0.
- Async rst pulse mid-stream (between clock edges) -> outputs go to 0 without waiting for a clock edge; the stream resumes with 2-cycle latency.
- WIDTH=1, thresh=0 and thresh=1: a≠b -> viol 1 and 0 respectively; hd never exceeds 1.
